// File: rtl/data_cache.sv
// Direct-mapped write-through, read-allocate data cache. Load hits complete in
// the same cycle; misses and all stores stall the core via cpu_ready until the memory acks.
module data_cache #(
  parameter int INDEX_BITS = 5
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [31:0]     cpu_addr,
  input  logic [0:3][7:0] cpu_wdata,
  output logic [0:3][7:0] cpu_rdata,
  output logic            cpu_ready,
  input  logic            halted,
  output logic            mm_req,
  output logic            mm_we,
  output logic [31:0]     mm_addr,
  output logic [0:3][7:0] mm_wdata,
  input  logic [0:3][7:0] mm_rdata,
  input  logic            mm_ack
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR_THRU
  } state_e;

  state_e                state_q, state_d;
  logic                  mm_req_q, mm_req_d;
  logic                  mm_we_q, mm_we_d;
  logic [31:0]           mm_addr_q, mm_addr_d;
  logic [0:3][7:0]       mm_wdata_q, mm_wdata_d;

  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [0:3][7:0]       data_q [LINES];

  logic [INDEX_BITS-1:0] cpu_idx;
  logic [TAG_BITS-1:0]   cpu_tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  hit;
  logic                  fill_en;
  logic                  store_en;
  logic                  unused_addr_bits;

  assign cpu_idx  = cpu_addr[INDEX_BITS+1:2];
  assign cpu_tag  = cpu_addr[31:INDEX_BITS+2];
  // The refill is steered by the registered miss address, so it lands even if the core drops its request.
  assign fill_idx = mm_addr_q[INDEX_BITS+1:2];
  assign fill_tag = mm_addr_q[31:INDEX_BITS+2];
  assign hit      = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

  assign unused_addr_bits = ^{cpu_addr[1:0], mm_addr_q[1:0]};

  always_comb begin
    state_d    = state_q;
    mm_req_d   = mm_req_q;
    mm_we_d    = mm_we_q;
    mm_addr_d  = mm_addr_q;
    mm_wdata_d = mm_wdata_q;
    cpu_ready  = 1'b0;
    cpu_rdata  = '0;
    fill_en    = 1'b0;
    store_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req && !halted) begin
          if (!cpu_we) begin
            if (hit) begin
              cpu_ready = 1'b1;
              cpu_rdata = data_q[cpu_idx];
            end else begin
              state_d   = RD_MISS;
              mm_req_d  = 1'b1;
              mm_we_d   = 1'b0;
              mm_addr_d = {cpu_addr[31:2], 2'b00};
            end
          end else begin
            store_en   = hit;
            state_d    = WR_THRU;
            mm_req_d   = 1'b1;
            mm_we_d    = 1'b1;
            mm_addr_d  = {cpu_addr[31:2], 2'b00};
            mm_wdata_d = cpu_wdata;
          end
        end
      end
      RD_MISS: begin
        if (mm_ack) begin
          fill_en  = 1'b1;
          mm_req_d = 1'b0;
          state_d  = IDLE;
        end
      end
      WR_THRU: begin
        if (mm_ack) begin
          cpu_ready = cpu_req;
          mm_req_d  = 1'b0;
          mm_we_d   = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      mm_req_q   <= 1'b0;
      mm_we_q    <= 1'b0;
      mm_addr_q  <= '0;
      mm_wdata_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      mm_req_q   <= mm_req_d;
      mm_we_q    <= mm_we_d;
      mm_addr_q  <= mm_addr_d;
      mm_wdata_q <= mm_wdata_d;
      if (fill_en) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mm_rdata;
    end else if (store_en) begin
      data_q[cpu_idx] <= cpu_wdata;
    end
  end

  assign mm_req   = mm_req_q;
  assign mm_we    = mm_we_q;
  assign mm_addr  = mm_addr_q;
  assign mm_wdata = mm_wdata_q;

endmodule
